circuit: RTL and testbench

- Streaming unsigned sum-of-squares accumulator.
- Each cycle with `en` high, the 32-bit sample `x` is squared and the result is added into a 100-bit running total `y`.
- It is a datapath leaf block fed by a sample source that can assert `en` on every cycle; it must sustain full throughput.
- It is implemented as a 2-stage pipeline: a partial-product squarer followed by an accumulator.

---
 rtl/circuit_pkg.sv | 28 ++
 rtl/circuit_square_pp.sv | 52 +++++
 rtl/circuit.sv | 50 +++++
 tb/tb_circuit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/circuit_pkg.sv
// Shared widths, the partial-product bundle and the recombination helper for
// the streaming sum-of-squares accumulator.
package circuit_pkg;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 100;
    localparam int HALF_W = DATA_W / 2;
    localparam int PP_W   = 2 * HALF_W;
    localparam int SQ_W   = 2 * DATA_W;

    typedef struct packed {
        logic [PP_W-1:0] hh;
        logic [PP_W-1:0] hl;
        logic [PP_W-1:0] ll;
    } pp_t;

    // x*x = (xh*xh << 32) + (2*xh*xl << 16) + xl*xl; the cross term appears once, so it shifts by 17
    function automatic logic [SQ_W-1:0] recombine_pp(input pp_t pp);
        logic [SQ_W-1:0] hh_s;
        logic [SQ_W-1:0] hl_s;
        logic [SQ_W-1:0] ll_s;
        hh_s = {pp.hh, {PP_W{1'b0}}};
        hl_s = {{(SQ_W-PP_W-HALF_W-1){1'b0}}, pp.hl, {(HALF_W+1){1'b0}}};
        ll_s = {{(SQ_W-PP_W){1'b0}}, pp.ll};
        return hh_s + hl_s + ll_s;
    endfunction

endpackage

// File: rtl/circuit_square_pp.sv
// Stage 1: registered 16x16 partial-product generator. The products are held
// while en is low; only the valid flag drops to mark a bubble.
module square_pp
    import circuit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    output pp_t               pp,
    output logic              v1
);

    logic [HALF_W-1:0] xh_s;
    logic [HALF_W-1:0] xl_s;
    pp_t               pp_d;
    pp_t               pp_q;
    logic              v1_d;
    logic              v1_q;

    // Next-state partial products and valid flag
    always_comb begin
        xh_s = x[DATA_W-1:HALF_W];
        xl_s = x[HALF_W-1:0];
        pp_d = pp_q;
        v1_d = 1'b0;
        if (en) begin
            pp_d.hh = PP_W'(xh_s) * PP_W'(xh_s);
            pp_d.hl = PP_W'(xh_s) * PP_W'(xl_s);
            pp_d.ll = PP_W'(xl_s) * PP_W'(xl_s);
            v1_d    = 1'b1;
        end else begin
            pp_d = pp_q;
            v1_d = 1'b0;
        end
    end

    // Stage-1 registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pp_q <= '0;
            v1_q <= 1'b0;
        end else begin
            pp_q <= pp_d;
            v1_q <= v1_d;
        end
    end

    assign pp = pp_q;
    assign v1 = v1_q;

endmodule

// File: rtl/circuit.sv
// Streaming unsigned sum-of-squares accumulator: stage 1 forms partial
// products, stage 2 recombines them into x*x and adds into a wrapping total.
module circuit
    import circuit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    output logic [ACC_W-1:0]  y
);

    pp_t              pp_s;
    logic             v1_s;
    logic [SQ_W-1:0]  sq_s;
    logic [ACC_W-1:0] y_d;
    logic [ACC_W-1:0] y_q;

    square_pp u_square_pp (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .x   (x),
        .pp  (pp_s),
        .v1  (v1_s)
    );

    // Recombine the square and form the next accumulator value (wraps silently)
    always_comb begin
        sq_s = recombine_pp(pp_s);
        y_d  = y_q;
        if (v1_s) begin
            y_d = y_q + ACC_W'(sq_s);
        end else begin
            y_d = y_q;
        end
    end

    // Accumulator register, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_circuit.sv
// Self-checking bench for the sum-of-squares accumulator: directed vector
// table, hand-written reset sequences and a randomized run against a model.
module tb_circuit;

    logic         clk;
    logic         rst;
    logic         en;
    logic [31:0]  x;
    logic [99:0]  y;

    int vectors;
    int miscompares;

    typedef struct {
        logic         rst_before;
        logic         en;
        logic [31:0]  x;
        logic [99:0]  exp_y;
    } vec_t;

    vec_t tbl[$];

    circuit dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .x   (x),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [99:0] act, input logic [99:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: y=%h expected %h", name, act, exp_v);
        end
    endtask

    task automatic add_vec(input logic rb, input logic e, input logic [31:0] xv, input logic [99:0] ev);
        vec_t v;
        v.rst_before = rb;
        v.en         = e;
        v.x          = xv;
        v.exp_y      = ev;
        tbl.push_back(v);
    endtask

    // Reset asserted between edges with en=1, x=5 driven; y must stay 0
    task automatic do_reset();
        @(negedge clk);
        en  = 1'b1;
        x   = 32'd5;
        rst = 1'b0;
        #1;
        check("reset_async", y, 100'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold", y, 100'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        x   = 32'd0;
    endtask

    // Drive one cycle of inputs, then sample y just after the edge
    task automatic step(input logic e, input logic [31:0] xv, output logic [99:0] y_after);
        @(negedge clk);
        en = e;
        x  = xv;
        @(posedge clk);
        #1;
        y_after = y;
    endtask

    logic [99:0] got;
    logic [99:0] ref_sum;
    logic [99:0] sq_ff;
    logic [99:0] pend_q[$];
    logic [31:0] rx;
    logic        re;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        en  = 1'b0;
        x   = 32'd0;

        sq_ff = 100'h0_FFFFFFFE_00000001;

        // single sample then hold
        add_vec(1'b1, 1'b1, 32'd3,  100'd0);
        add_vec(1'b0, 1'b0, 32'd7,  100'd9);
        add_vec(1'b0, 1'b0, 32'd7,  100'd9);
        // back-to-back samples
        add_vec(1'b1, 1'b1, 32'd3,  100'd0);
        add_vec(1'b0, 1'b1, 32'd4,  100'd9);
        add_vec(1'b0, 1'b1, 32'd12, 100'd25);
        add_vec(1'b0, 1'b0, 32'd0,  100'd169);
        add_vec(1'b0, 1'b0, 32'd0,  100'd169);
        // max sample once
        add_vec(1'b1, 1'b1, 32'hFFFFFFFF, 100'd0);
        add_vec(1'b0, 1'b0, 32'd0, sq_ff);
        add_vec(1'b0, 1'b0, 32'd0, sq_ff);
        // max sample twice: carry into bit 64
        add_vec(1'b1, 1'b1, 32'hFFFFFFFF, 100'd0);
        add_vec(1'b0, 1'b1, 32'hFFFFFFFF, 100'd0 + sq_ff);
        add_vec(1'b0, 1'b0, 32'd0, 100'h1_FFFFFFFC_00000002);
        add_vec(1'b0, 1'b0, 32'd0, 100'h1_FFFFFFFC_00000002);
        // en toggling: x=99 samples with en=0 ignored
        add_vec(1'b1, 1'b1, 32'd2,  100'd0);
        add_vec(1'b0, 1'b0, 32'd99, 100'd4);
        add_vec(1'b0, 1'b1, 32'd2,  100'd4);
        add_vec(1'b0, 1'b0, 32'd99, 100'd8);
        add_vec(1'b0, 1'b0, 32'd99, 100'd8);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) do_reset();
            step(tbl[i].en, tbl[i].x, got);
            check($sformatf("table[%0d]", i), got, tbl[i].exp_y);
        end

        // Random run: a sample's square lands in y one edge after acceptance
        do_reset();
        ref_sum = 100'd0;
        pend_q.delete();
        for (int i = 0; i < 200; i++) begin
            rx = $urandom();
            re = (i < 100) ? 1'b1 : 1'($urandom_range(0, 1));
            step(re, rx, got);
            while (pend_q.size() > 0) ref_sum = ref_sum + pend_q.pop_front();
            if (re) pend_q.push_back(100'(rx) * 100'(rx));
            check("random", got, ref_sum);
        end
        step(1'b0, 32'd0, got);
        while (pend_q.size() > 0) ref_sum = ref_sum + pend_q.pop_front();
        check("random_final", got, ref_sum);
        step(1'b0, 32'd0, got);
        check("random_hold", got, ref_sum);

        // Reset mid-operation with a sample in stage 1
        do_reset();
        step(1'b1, 32'd3, got);
        step(1'b1, 32'd4, got);
        check("midrst_pre", got, 100'd9);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_async", y, 100'd0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd4, got);
            check("midrst_discard", got, 100'd0);
        end
        step(1'b1, 32'd5, got);
        step(1'b0, 32'd0, got);
        check("midrst_after", got, 100'd25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
